// File: rtl/rx_audio_frame_mux_pkg.sv
// Shared definitions for the rx audio frame mux: FSM encoding, parameter defaults
// and a width helper.
package rx_audio_frame_mux_pkg;

    localparam int DEF_NRX      = 4;
    localparam int DEF_WPS      = 3;
    localparam int DEF_TS_WORDS = 3;
    localparam int DEF_DEPTH    = 8192;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WAIT,
        ST_TS,
        ST_CTR,
        ST_COMMIT
    } state_t;

    // Counter width for values 0..n-1, never less than one bit.
    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame RAM, single clock, registered read port.
module rx_frame_ram
    import rx_audio_frame_mux_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/rx_audio_frame_mux.sv
// Frames NRX-channel sample sets with timestamp and counter into a circular buffer;
// frames become visible to the reader only on commit, or are dropped whole.
module rx_audio_frame_mux
    import rx_audio_frame_mux_pkg::*;
#(
    parameter int NRX      = DEF_NRX,
    parameter int WPS      = DEF_WPS,
    parameter int TS_WORDS = DEF_TS_WORDS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                     adc_clk,
    input  logic                     reset_n,
    input  logic [15:0]              nrx_samps,
    input  logic                     rx_avail,
    input  logic [15:0]              rx_din,
    input  logic [16*TS_WORDS-1:0]   ticks,
    output logic                     rd_get,
    output logic [3:0]               rxn_o,
    input  logic                     rd_en,
    output logic [15:0]              rd_dout,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done,
    output logic [15:0]              buf_ctr,
    output logic [15:0]              drop_cnt,
    output logic                     overflow,
    output logic                     seq_err,
    input  logic                     clr_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SETW = NRX * WPS;
    localparam int SWW  = cw(SETW);
    localparam int WPW  = cw(WPS);
    localparam int TSW  = cw(TS_WORDS);

    state_t                     state;
    logic [AW:0]                wp_work, wp_commit, rp;
    logic [15:0]                nsamps_lat, set_cnt;
    logic [TS_WORDS-1:0][15:0]  ticks_lat;
    logic                       drop;
    logic [SWW-1:0]             word_cnt;
    logic [WPW-1:0]             wps_cnt;
    logic [TSW-1:0]             ts_idx;
    logic [31:0]                frame_len, space;
    logic                       we, re;
    logic [15:0]                wdata;

    assign level     = wp_commit - rp;
    assign frame_len = 32'(nrx_samps) * 32'(SETW) + 32'(TS_WORDS + 1);
    assign space     = 32'(DEPTH) - 32'(level);
    assign re        = rd_en && (level != '0);

    always_comb begin
        we    = 1'b0;
        wdata = buf_ctr;
        case (state)
            ST_MOVE: begin we = 1'b1; wdata = rx_din; end
            ST_TS:   begin we = 1'b1; wdata = ticks_lat[ts_idx]; end
            ST_CTR:  we = 1'b1;
            default: we = 1'b0;
        endcase
        we = we & ~drop;
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wp_work    <= '0;
            wp_commit  <= '0;
            nsamps_lat <= '0;
            set_cnt    <= '0;
            ticks_lat  <= '0;
            drop       <= 1'b0;
            word_cnt   <= '0;
            wps_cnt    <= '0;
            ts_idx     <= '0;
            rd_get     <= 1'b0;
            rxn_o      <= '0;
            frame_done <= 1'b0;
            buf_ctr    <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (rx_avail && (state inside {ST_MOVE, ST_TS, ST_CTR, ST_COMMIT}))
                seq_err <= 1'b1;
            case (state)
                ST_IDLE: if (rx_avail) begin
                    nsamps_lat <= nrx_samps;
                    ticks_lat  <= ticks;
                    drop       <= space < frame_len;
                    set_cnt    <= '0;
                    ts_idx     <= '0;
                    word_cnt   <= '0;
                    wps_cnt    <= '0;
                    rxn_o      <= '0;
                    if (nrx_samps == '0) begin
                        state <= ST_TS;
                    end else begin
                        state  <= ST_MOVE;
                        rd_get <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    wp_work <= wp_work + 1'b1;
                    if (word_cnt == SWW'(SETW - 1)) begin
                        rd_get  <= 1'b0;
                        rxn_o   <= '0;
                        set_cnt <= set_cnt + 16'd1;
                        state   <= (set_cnt + 16'd1 == nsamps_lat) ? ST_TS : ST_WAIT;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        if (wps_cnt == WPW'(WPS - 1)) begin
                            wps_cnt <= '0;
                            rxn_o   <= rxn_o + 4'd1;
                        end else begin
                            wps_cnt <= wps_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: if (rx_avail) begin
                    state    <= ST_MOVE;
                    rd_get   <= 1'b1;
                    word_cnt <= '0;
                    wps_cnt  <= '0;
                    rxn_o    <= '0;
                end
                ST_TS: begin
                    wp_work <= wp_work + 1'b1;
                    if (ts_idx == TSW'(TS_WORDS - 1)) state <= ST_CTR;
                    else                              ts_idx <= ts_idx + 1'b1;
                end
                // Commit bookkeeping happens on the edge that writes the counter word,
                // so level and frame_done are visible in the following (COMMIT) cycle.
                ST_CTR: begin
                    state      <= ST_COMMIT;
                    frame_done <= 1'b1;
                    if (!drop) begin
                        wp_work   <= wp_work + 1'b1;
                        wp_commit <= wp_work + 1'b1;
                        buf_ctr   <= buf_ctr + 16'd1;
                    end else begin
                        wp_work  <= wp_commit;
                        overflow <= 1'b1;
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
            if (clr_err) begin
                overflow <= 1'b0;
                seq_err  <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            rp       <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) rp <= rp + 1'b1;
        end
    end

    rx_frame_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (adc_clk),
        .rst_n (reset_n),
        .we    (we),
        .waddr (wp_work[AW-1:0]),
        .wdata (wdata),
        .re    (re),
        .raddr (rp[AW-1:0]),
        .rdata (rd_dout)
    );

endmodule

// File: doc/rx_audio_frame_mux.md
# rx_audio_frame_mux

Parametrised successor to the rx audio shared sample memory, single clock (adc_clk). Collects per-channel I/Q(/WB) words from NRX receivers into frames of nrx_samps sample sets, appends a frame-start timestamp and a frame counter, and stores whole frames in a circular buffer. Frames commit atomically: a partial frame is never visible to the reader, and a frame that will not fit is dropped whole with the source still drained. Sits between the DDC outputs and the SPI/CPU-side transfer logic; any CDC is external.

## Interface
- NRX, 4: receiver channels per sample set (1..16)
- WPS, 3: 16-bit words per channel per sample (3 = IQ 24-bit, 4 = IQ + WB)
- TS_WORDS, 3: timestamp words (16 bits each, LSW first)
- DEPTH, 8192: buffer words, power of two
- AW = clog2(DEPTH): derived, not overridable

- adc_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- nrx_samps  in  16  sample sets per frame, latched at frame start
- rx_avail  in  1  one-cycle pulse: a full NRX sample set is ready
- rx_din  in  16  source word, valid in the same cycle as rd_get
- ticks  in  16*TS_WORDS  free-running timestamp
- rd_get  out  1  source advance strobe, one per word consumed
- rxn_o  out  4  channel currently being moved
- rd_en  in  1  consumer read request
- rd_dout  out  16  read data
- rd_valid  out  1  rd_dout valid
- level  out  AW+1  committed words available to read
- frame_done  out  1  one-cycle pulse on commit (or drop) of a frame
- buf_ctr  out  16  committed frame count, wraps
- drop_cnt  out  16  dropped frames, saturates at 0xFFFF
- overflow  out  1  sticky: at least one frame dropped
- seq_err  out  1  sticky: rx_avail arrived while a set was in flight
- clr_err  in  1  clears overflow, seq_err, drop_cnt

## Operation
- Frame length L = nrx_samps*NRX*WPS + TS_WORDS + 1, computed in 32 bits at frame start.
- States:
  - IDLE: on rx_avail, latch nrx_samps and ticks, compute L, and set drop = (DEPTH − level − 0 < L). If nrx_samps==0, go to TS; else go to MOVE.
  - MOVE: one word per cycle for NRX*WPS cycles, with rd_get=1 and write enabled unless drop. rxn_o steps once every WPS words. After the last word, set_cnt++. If set_cnt==nrx_samps, go to TS; else go to WAIT.
  - WAIT: on rx_avail, go to MOVE.
  - TS: TS_WORDS cycles writing latched ticks, LSW first, with rd_get=0.
  - CTR: one cycle writing the buf_ctr value being committed (pre-increment).
  - COMMIT: if !drop, wp_commit ← wp_work and buf_ctr++. Otherwise wp_work ← wp_commit, drop_cnt++, and overflow ← 1. Pulse frame_done, then go to IDLE.
- rx_avail in MOVE/TS/CTR/COMMIT is ignored and sets seq_err; the next frame's timing is unaffected.
- The read side uses only committed data:
  - level = wp_commit − rp, modulo 2^(AW+1).
  - An rd_en with level==0 is ignored: no pointer move, rd_valid stays 0.
- Pointers are AW+1 bits with an extra wrap bit, so full (level==DEPTH) and empty (level==0) are distinct.
- If clr_err and a drop commit coincide, the clear wins for overflow and drop_cnt, but that frame still counts as dropped.

## Timing
- Reset values: rd_get=0, rxn_o=0, rd_valid=0, rd_dout=0, level=0, frame_done=0, buf_ctr=0, drop_cnt=0, overflow=0, seq_err=0, state=IDLE, all pointers 0.
- Latencies:
  - rx_avail → first rd_get: 1 cycle.
  - Set move time: exactly NRX*WPS cycles.
  - Last CTR write → frame_done and level update: 1 cycle.
- Read: rd_en in cycle n → rd_dout/rd_valid in cycle n+1, because the RAM read is registered. Back-to-back reads run at 1 word/cycle.
- Simultaneous commit and read in the same cycle: both pointers update, and level reflects both the next cycle.
- A write and a read of the same address cannot collide: reads only touch committed addresses.
- Reset asserted mid-frame: abandon the frame immediately, clear all state, discard uncommitted data. The source realignment belongs to its owner.

## Structure
- Shared package/include (kiwi.gen.vh generator) provides: state encoding localparams, NRX/WPS/DEPTH defaults, clog2.
- One sub-module, rx_frame_ram: simple dual-port RAM, one clock, registered read port, DEPTH×16.
- The control FSM, pointers and counters live in the top module.

## Test plan
- Basic frame: NRX=4, WPS=3, nrx_samps=2, ticks=0x0003_0002_0001.
  - Expect 24 rd_get pulses, then L=28 and frame_done.
  - Readback: 24 data words, then 0x0001, 0x0002, 0x0003, 0x0000.
- Wrap: DEPTH=64, L=28. Write 5 frames, reading each.
  - Data is intact across the pointer wrap, and level returns to 0 after each frame.
- Overflow: DEPTH=64, no reads, L=28.
  - Frames 1–2 commit, giving level=56.
  - Frame 3 still produces 24 rd_get pulses, but level stays 56, overflow=1, drop_cnt=1, buf_ctr=2.
- Zero length: nrx_samps=0.
  - No rd_get; L=4; frame contains ticks plus the counter.
- seq_err: rx_avail pulse during MOVE.
  - seq_err=1, and the frame completes with exactly NRX*WPS*nrx_samps words.
- Reset: deassert reset_n mid-MOVE.
  - All outputs return to their reset values, and the next frame's counter word reads 0x0000.
